// File: rtl/chunk_mofs_sink.sv
// chunk_mofs_sink
//   Receiving end of the per-configuration memory-offset stream. Each
//   accepted non-skip beat is turned into a linear word address
//   base[id] + sum(mofs[d] * pitch[id][d]) (modulo 2^WBW) through a
//   two-stage pipeline. Skipped beats are consumed without producing output.
//   The block also checks id ordering within a group and counts the
//   groups that complete.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_mofs_rdy/_ack     input beat handshake (ack is combinational)
//   i_mofs, i_id,       offset vector, configuration id, skip flag
//   i_skip
//   i_beg, i_end        group id range [beg, end), quasi-static
//   i_base, i_pitch     per-config base address and per-dimension pitch
//   o_addr_rdy/_ack     output beat handshake (rdy is registered)
//   o_addr, o_id,       linear address, its id, last-of-group marker
//   o_last
//   o_ngrp              wrapping count of completed groups
//   o_err               sticky id-order error
module chunk_mofs_sink #(
   parameter  int WBW     = 16,
   parameter  int DIM     = 6,
   parameter  int N_ICFG  = 5,
   localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_mofs_rdy,
   output logic                                 i_mofs_ack,
   input  logic [DIM-1:0][WBW-1:0]              i_mofs,
   input  logic [ICFG_BW-1:0]                   i_id,
   input  logic                                 i_skip,
   input  logic [ICFG_BW-1:0]                   i_beg,
   input  logic [ICFG_BW-1:0]                   i_end,
   input  logic [N_ICFG-1:0][WBW-1:0]           i_base,
   input  logic [N_ICFG-1:0][DIM-1:0][WBW-1:0]  i_pitch,
   output logic                                 o_addr_rdy,
   input  logic                                 o_addr_ack,
   output logic [WBW-1:0]                       o_addr,
   output logic [ICFG_BW-1:0]                   o_id,
   output logic                                 o_last,
   output logic [WBW-1:0]                       o_ngrp,
   output logic                                 o_err
);

   // Product truncated to the address width; the full-width product is
   // formed first so the low bits are exact.
   function automatic logic [WBW-1:0] mul_trunc(input logic [WBW-1:0] a,
                                                input logic [WBW-1:0] b);
      logic [2*WBW-1:0] full;
      full = a * b;
      return full[WBW-1:0];
   endfunction

   // Modular address sum of the base and every per-dimension product.
   function automatic logic [WBW-1:0] addr_sum(input logic [WBW-1:0]          base,
                                               input logic [DIM-1:0][WBW-1:0] prod);
      logic [WBW-1:0] acc;
      acc = base;
      for (int d = 0; d < DIM; d++) begin
         acc = acc + prod[d];
      end
      return acc;
   endfunction

   // Pipeline control
   logic vld_p1_q, vld_p2_q;
   logic s1_can_load, s2_can_load;
   logic accept, load_p1;

   // Stage-1 data
   logic [DIM-1:0][WBW-1:0] prod_p1_d, prod_p1_q;
   logic [WBW-1:0]          base_p1_q;
   logic [ICFG_BW-1:0]      id_p1_q;
   logic                    last_p1_q;

   // Stage-2 (output) data
   logic [WBW-1:0]          addr_p2_q;
   logic [ICFG_BW-1:0]      id_p2_q;
   logic                    last_p2_q;

   // Id tracker and group counter
   logic                    open_q, open_d;
   logic [ICFG_BW-1:0]      exp_q, exp_d;
   logic [WBW-1:0]          ngrp_q, ngrp_d;
   logic                    err_q, err_d;
   logic [ICFG_BW-1:0]      id_inc;
   logic [ICFG_BW-1:0]      exp_id;
   logic                    in_last;

   assign s2_can_load = !vld_p2_q || o_addr_ack;
   assign s1_can_load = !vld_p1_q || s2_can_load;

   // Skip beats never enter the pipeline, so they are taken regardless of stall.
   assign accept     = i_mofs_rdy && (i_skip || s1_can_load);
   assign load_p1    = accept && !i_skip;
   assign i_mofs_ack = accept;

   assign id_inc  = i_id + ICFG_BW'(1);
   assign in_last = (id_inc == i_end);
   assign exp_id  = open_q ? exp_q : i_beg;

   always_comb begin
      prod_p1_d = '0;
      for (int d = 0; d < DIM; d++) begin
         prod_p1_d[d] = mul_trunc(i_mofs[d], i_pitch[i_id][d]);
      end
   end

   always_comb begin
      open_d = open_q;
      exp_d  = exp_q;
      ngrp_d = ngrp_q;
      err_d  = err_q;
      if (accept) begin
         if (i_id != exp_id) begin
            err_d = 1'b1;
         end
         exp_d  = id_inc;
         open_d = !in_last;
         if (in_last) begin
            ngrp_d = ngrp_q + WBW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         open_q <= 1'b0;
         exp_q  <= '0;
         ngrp_q <= '0;
         err_q  <= 1'b0;
      end else begin
         open_q <= open_d;
         exp_q  <= exp_d;
         ngrp_q <= ngrp_d;
         err_q  <= err_d;
      end
   end

   // ---- Stage 1: per-dimension products and base lookup ----
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         vld_p1_q <= 1'b0;
      end else if (load_p1) begin
         vld_p1_q <= 1'b1;
      end else if (s2_can_load) begin
         vld_p1_q <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (load_p1) begin
         prod_p1_q <= prod_p1_d;
         base_p1_q <= i_base[i_id];
         id_p1_q   <= i_id;
         last_p1_q <= in_last;
      end
   end

   // ---- Stage 2: address sum into the output register ----
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         vld_p2_q  <= 1'b0;
         addr_p2_q <= '0;
         id_p2_q   <= '0;
         last_p2_q <= 1'b0;
      end else if (s2_can_load) begin
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            addr_p2_q <= addr_sum(base_p1_q, prod_p1_q);
            id_p2_q   <= id_p1_q;
            last_p2_q <= last_p1_q;
         end
      end
   end

   assign o_addr_rdy = vld_p2_q;
   assign o_addr     = addr_p2_q;
   assign o_id       = id_p2_q;
   assign o_last     = last_p2_q;
   assign o_ngrp     = ngrp_q;
   assign o_err      = err_q;

endmodule

// File: doc/chunk_mofs_sink.md
# chunk_mofs_sink

Receiving end of the per-configuration memory-offset stream in the read pipeline. Each beat carries an N-dimensional offset vector, a configuration id and a systolic-skip flag. The block consumes the beats over a rdy/ack handshake and drops skipped beats. Surviving beats become linear word addresses (`base + Σ mofs·pitch`) in a 2-stage pipeline, which feeds the chunk address looper. The block also checks id ordering and counts completed groups.

## Interface
- `WBW`, 16, word/offset/address width
- `DIM`, 6, offset vector dimensions
- `N_ICFG`, 5, number of input configurations; `ICFG_BW = $clog2(N_ICFG+1)` is derived
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, asynchronous, active-low
- `i_mofs_rdy`  in  1  input beat valid (source side of rdy/ack)
- `i_mofs_ack`  out  1  input beat accepted, combinational
- `i_mofs`  in  WBW×[DIM]  offset vector
- `i_id`  in  ICFG_BW  configuration id of beat
- `i_skip`  in  1  beat is skipped
- `i_beg`, `i_end`  in  ICFG_BW  id range [beg, end) of one group; quasi-static
- `i_base`  in  WBW×[N_ICFG]  base address per config; quasi-static
- `i_pitch`  in  WBW×[N_ICFG][DIM]  pitch per config and dimension; quasi-static
- `o_addr_rdy`  out  1  output beat valid
- `o_addr_ack`  in  1  downstream accept
- `o_addr`  out  WBW  linear address
- `o_id`  out  ICFG_BW  id of output beat
- `o_last`  out  1  output beat has id == i_end-1
- `o_ngrp`  out  WBW  count of completed groups, wraps
- `o_err`  out  1  sticky id-order error

## Operation
- Handshake: a transfer occurs on a cycle with rdy && ack. A source holds its data stable from rdy assertion until ack. `o_addr_rdy` must not depend combinationally on `o_addr_ack`.
- Input accept:
  - Skip beat (`i_skip`=1): `i_mofs_ack = i_mofs_rdy`, always accepted. It updates the id tracker and group counter and produces no output.
  - Non-skip beat: `i_mofs_ack = i_mofs_rdy && s1_can_load`.
- Pipeline S1: registers `prod[d] = (i_mofs[d]*i_pitch[i_id][d])[WBW-1:0]` and `base = i_base[i_id]`, plus id and last.
- Pipeline S2 (output register): `o_addr = base + Σprod`, modulo 2^WBW.
- Stall and flow:
  - `s2_can_load = !s2_v || o_addr_ack`.
  - `s1_can_load = !s1_v || s2_can_load`.
  - The pipeline sustains 1 beat/cycle with no bubbles under continuous ack.
- Id tracker: registers `open` and `exp`.
  - On each accepted beat, the expected id is `open ? exp : i_beg`.
  - If `i_id` differs from the expected id, `o_err` is set to 1 and held until reset. The beat is still processed normally.
  - After the check, `exp <= i_id+1`.
  - `open <= (i_id+1 != i_end)`.
- Group counter: increments by 1 on every accepted beat with `i_id+1 == i_end`, skip or not. It wraps at 2^WBW.
- `o_last` is computed at input as `i_id+1 == i_end`. A group whose final beat is skipped emits no `o_last`; downstream uses `o_ngrp` for that case.
- `i_id >= N_ICFG` is out of contract. The table index is not checked.

## Timing
- Reset values: `o_addr_rdy`=0, `o_addr`=0, `o_id`=0, `o_last`=0, `o_ngrp`=0, `o_err`=0. Internal `s1_v`=0, `s2_v`=0, `open`=0, `exp`=0.
- Reset mid-operation: asynchronous assertion immediately drops `o_addr_rdy`. In-flight beats are discarded and the next beat starts a new group.
- Latency: a non-skip beat accepted at edge k has `o_addr_rdy`=1 after edge k+1, so it is visible in the following cycle.
- Backpressure: when S2 is held, S1 fills, then `i_mofs_ack` drops for non-skip beats. Skip beats are still accepted while the pipeline is stalled.
- Simultaneous S2 drain and S1→S2 load in the same cycle: S2 takes the new value and holds `o_addr_rdy`=1. No bubble is inserted.
- Quasi-static inputs may change only while `s1_v`=`s2_v`=0 and no input beat is pending.

## Test plan
- Single group, no skip. Setup: beg=0, end=3, DIM=2, base={100,200,300}, pitch[c]={1,16}. Feed mofs {2,1},{0,3},{5,0} with ids 0,1,2. Required outputs: addrs 118, 248, 305; o_last only on the third; o_ngrp=1; o_err=0.
- Skip filtering. Same group with id1 skipped: outputs are only 118 and 305. With id2 skipped instead: no o_last is emitted, but o_ngrp still increments to 1.
- Backpressure. Hold `o_addr_ack`=0 for 5 cycles while 4 non-skip beats are offered. Exactly 2 are accepted and `o_addr` stays stable. After release, all 4 emerge in order, one per cycle.
- Id order error. With beg=1, end=3, send ids 1,1,2: o_err rises after the second beat and stays 1; all three addresses are still emitted.
- Wrap and reset. pitch=0xFFFF and mofs=2 give product 0xFFFE, so base 3 yields addr 0x0001. Assert `i_rst` while S1 and S2 are both valid: `o_addr_rdy` is 0 immediately and the first beat after reset is checked against i_beg.
